prv664_decode_queue: RTL

- 2-wide in, 2-wide out FIFO between the decoder and the dispatch unit.
- Stores decoded instruction packets in program order.
- Presents the two oldest entries as instr0/instr1 to dispatch.
- Retires 0, 1 or 2 entries per cycle according to dispatch acceptance; cleared on pipeline flush.

---
 rtl/prv664_pkg.sv | 35 +++
 rtl/prv664_dq_ptr.sv | 56 +++++
 rtl/prv664_decode_queue.sv | 117 +++++++++++
 3 files changed

// File: rtl/prv664_pkg.sv
// Shared decode-packet definitions for the prv664 front end.
// DECODE_PKT_W is derived from decode_pkt_t so the two cannot drift apart.
package prv664_pkg;

    typedef struct packed {
        logic [63:0] pc;
        logic [7:0]  itag;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rs1_en;
        logic        rs2_en;
        logic        rd_en;
        logic [3:0]  disp_dest;
        logic [16:0] rsvd;
    } decode_pkt_t;

    localparam int DECODE_PKT_W = $bits(decode_pkt_t);

    // Number of queue slots moved per cycle: 0, 1 or 2.
    typedef logic [1:0] slot_cnt_t;

    function automatic logic [DECODE_PKT_W-1:0] pack_pkt(input decode_pkt_t pkt);
        return pkt;
    endfunction

    function automatic decode_pkt_t unpack_pkt(input logic [DECODE_PKT_W-1:0] bits);
        return decode_pkt_t'(bits);
    endfunction

endpackage

// File: rtl/prv664_dq_ptr.sv
// Pointer and occupancy arithmetic for the decode queue.
// Purely combinational; the top owns the registers and the storage.
module prv664_dq_ptr
    import prv664_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          flush_i,
    input  logic          in0_valid_i,
    input  logic          in1_valid_i,
    input  logic          pop0_i,
    input  logic          pop1_i,
    input  logic [PW-1:0] rptr_q_i,
    input  logic [PW-1:0] wptr_q_i,
    input  logic [CW-1:0] count_q_i,
    output slot_cnt_t     push_n_o,
    output slot_cnt_t     pop_n_o,
    output logic [PW-1:0] rptr_d_o,
    output logic [PW-1:0] wptr_d_o,
    output logic [CW-1:0] count_d_o,
    output logic          in_ready_o,
    output logic          out0_valid_o,
    output logic          out1_valid_o
);

    // Ready looks only at the registered count, so a same-cycle pop never
    // feeds back into the decoder handshake.
    assign in_ready_o   = (count_q_i <= CW'(DEPTH - 2));
    assign out0_valid_o = (count_q_i != '0);
    assign out1_valid_o = (count_q_i >= CW'(2));

    always_comb begin
        push_n_o  = '0;
        pop_n_o   = '0;
        rptr_d_o  = rptr_q_i;
        wptr_d_o  = wptr_q_i;
        count_d_o = count_q_i;
        if (flush_i) begin
            rptr_d_o  = '0;
            wptr_d_o  = '0;
            count_d_o = '0;
        end else begin
            if (in_ready_o) begin
                push_n_o = {1'b0, in0_valid_i} + {1'b0, in1_valid_i};
            end
            pop_n_o   = {1'b0, pop0_i & out0_valid_o}
                      + {1'b0, pop0_i & pop1_i & out1_valid_o};
            rptr_d_o  = rptr_q_i + PW'(pop_n_o);
            wptr_d_o  = wptr_q_i + PW'(push_n_o);
            count_d_o = count_q_i + CW'(push_n_o) - CW'(pop_n_o);
        end
    end

endmodule

// File: rtl/prv664_decode_queue.sv
// 2-in / 2-out in-order decode queue between decoder and dispatch.
// Optional perf counters when PRV664_DECODE_QUEUE_PERF_EN is defined.
module prv664_decode_queue
    import prv664_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = DECODE_PKT_W,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              flush_i,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in_ready,
    output logic              out0_valid,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    output logic [DATA_W-1:0] out1_data,
    input  logic              pop0,
    input  logic              pop1,
    output logic [CW-1:0]     count_o
`ifdef PRV664_DECODE_QUEUE_PERF_EN
    ,
    output logic [31:0]       stall_full_cnt_o,
    output logic [31:0]       dual_pop_cnt_o
`endif
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [CW-1:0]     count_q, count_d;
    slot_cnt_t         push_n, pop_n;
    logic [PW-1:0]     rptr_p1, wptr_p1;
    logic [DATA_W-1:0] slot0_data;

    prv664_dq_ptr #(.DEPTH(DEPTH)) u_ptr (
        .flush_i      (flush_i),
        .in0_valid_i  (in0_valid),
        .in1_valid_i  (in1_valid),
        .pop0_i       (pop0),
        .pop1_i       (pop1),
        .rptr_q_i     (rptr_q),
        .wptr_q_i     (wptr_q),
        .count_q_i    (count_q),
        .push_n_o     (push_n),
        .pop_n_o      (pop_n),
        .rptr_d_o     (rptr_d),
        .wptr_d_o     (wptr_d),
        .count_d_o    (count_d),
        .in_ready_o   (in_ready),
        .out0_valid_o (out0_valid),
        .out1_valid_o (out1_valid)
    );

    assign rptr_p1 = rptr_q + PW'(1);
    assign wptr_p1 = wptr_q + PW'(1);

    // Compaction: a lone in1 packet lands in the first free slot.
    assign slot0_data = in0_valid ? in0_data : in1_data;

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            if (push_n != 2'd0) begin
                mem_q[wptr_q] <= slot0_data;
            end
            if (push_n == 2'd2) begin
                mem_q[wptr_p1] <= in1_data;
            end
        end
    end

    assign out0_data = out0_valid ? mem_q[rptr_q]  : '0;
    assign out1_data = out1_valid ? mem_q[rptr_p1] : '0;
    assign count_o   = count_q;

`ifdef PRV664_DECODE_QUEUE_PERF_EN
    logic [31:0] stall_full_q;
    logic [31:0] dual_pop_q;
    logic        stall_evt;

    assign stall_evt = (in0_valid | in1_valid) & ~in_ready;

    // Saturating; deliberately untouched by flush so they span flushes.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            stall_full_q <= '0;
            dual_pop_q   <= '0;
        end else begin
            if (stall_evt && (stall_full_q != '1)) begin
                stall_full_q <= stall_full_q + 32'd1;
            end
            if ((pop_n == 2'd2) && (dual_pop_q != '1)) begin
                dual_pop_q <= dual_pop_q + 32'd1;
            end
        end
    end

    assign stall_full_cnt_o = stall_full_q;
    assign dual_pop_cnt_o   = dual_pop_q;
`endif

endmodule
